// File: rtl/iir_biquad_cascade.sv
// Multi-channel cascade of Direct Form I biquads sharing one multiplier (5 MAC cycles + 1 store per stage).
// Optional: define IIR_BIQUAD_CASCADE_SAT_EN to saturate each stage result instead of wrapping it.
module iir_biquad_cascade #(
  parameter int N_BITS_P          = 32,
  parameter int Q_BITS_P          = 15,
  parameter int NR_OF_STAGES_P    = 4,
  parameter int NR_OF_CHANNELS_P  = 2,
  parameter int CH_WIDTH_P        = 1,
  parameter int COEF_ADDR_WIDTH_P = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         x_valid,
  output logic                         x_ready,
  input  logic signed [N_BITS_P-1:0]   x,
  input  logic [CH_WIDTH_P-1:0]        x_channel,
  output logic                         y_valid,
  output logic signed [N_BITS_P-1:0]   y,
  output logic [CH_WIDTH_P-1:0]        y_channel,
  input  logic                         cr_coef_wen,
  input  logic [COEF_ADDR_WIDTH_P-1:0] cr_coef_addr,
  input  logic [N_BITS_P-1:0]          cr_coef_wdata,
  input  logic [NR_OF_STAGES_P-1:0]    cr_bypass,
  input  logic                         clear_state
);

  localparam int PROD_W = 2 * N_BITS_P;
  localparam int ACC_W  = 2 * N_BITS_P + 3;
  localparam int NCOEF  = 5 * NR_OF_STAGES_P;
  localparam int S_W    = (NR_OF_STAGES_P > 1) ? $clog2(NR_OF_STAGES_P) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MAC    = 2'd1;
  localparam logic [1:0] STORE  = 2'd2;
  localparam logic [1:0] OUTPUT = 2'd3;

  localparam logic [COEF_ADDR_WIDTH_P-1:0] FIVE_C  = COEF_ADDR_WIDTH_P'(32'd5);
  localparam logic [COEF_ADDR_WIDTH_P-1:0] NCOEF_C = COEF_ADDR_WIDTH_P'(NCOEF);
  localparam logic [S_W-1:0]               LAST_C  = S_W'(NR_OF_STAGES_P - 1);

`ifdef IIR_BIQUAD_CASCADE_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX_C = {{(ACC_W-N_BITS_P+1){1'b0}}, {(N_BITS_P-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN_C = {{(ACC_W-N_BITS_P+1){1'b1}}, {(N_BITS_P-1){1'b0}}};
`endif

  // Narrow the shifted accumulator to a sample word (saturate or wrap).
  function automatic logic [N_BITS_P-1:0] reduce_f(input logic signed [ACC_W-1:0] v);
`ifdef IIR_BIQUAD_CASCADE_SAT_EN
    if (v > SAT_MAX_C) begin
      reduce_f = SAT_MAX_C[N_BITS_P-1:0];
    end else if (v < SAT_MIN_C) begin
      reduce_f = SAT_MIN_C[N_BITS_P-1:0];
    end else begin
      reduce_f = v[N_BITS_P-1:0];
    end
`else
    reduce_f = v[N_BITS_P-1:0];
`endif
  endfunction

  logic [1:0]                   state_r;
  logic [S_W-1:0]               s_r;
  logic [2:0]                   k_r;
  logic [CH_WIDTH_P-1:0]        ch_r;
  logic                         ch_valid_r;
  logic                         bypass_r;
  logic                         clr_pend_r;
  logic signed [N_BITS_P-1:0]   stage_in_r;
  logic signed [ACC_W-1:0]      acc_r;
  logic                         x_ready_r;
  logic                         y_valid_r;
  logic signed [N_BITS_P-1:0]   y_r;
  logic [CH_WIDTH_P-1:0]        y_ch_r;

  logic [N_BITS_P-1:0]          shadow_r [NCOEF];
  logic [N_BITS_P-1:0]          active_r [NCOEF];
  logic signed [N_BITS_P-1:0]   x1_r [NR_OF_CHANNELS_P][NR_OF_STAGES_P];
  logic signed [N_BITS_P-1:0]   x2_r [NR_OF_CHANNELS_P][NR_OF_STAGES_P];
  logic signed [N_BITS_P-1:0]   y1_r [NR_OF_CHANNELS_P][NR_OF_STAGES_P];
  logic signed [N_BITS_P-1:0]   y2_r [NR_OF_CHANNELS_P][NR_OF_STAGES_P];

  logic                         accept_s;
  logic                         ch_valid_s;
  logic                         clear_now_s;
  logic                         byp0_s;
  logic                         byp_next_s;
  logic [S_W-1:0]               s_next_s;
  logic [CH_WIDTH_P-1:0]        ch_idx_s;
  logic [COEF_ADDR_WIDTH_P-1:0] coef_idx_s;
  logic [N_BITS_P-1:0]          coef_s;
  logic [N_BITS_P-1:0]          op_s;
  logic [PROD_W-1:0]            prod_s;
  logic [ACC_W-1:0]             prod_ext_s;
  logic signed [ACC_W-1:0]      shifted_s;
  logic signed [N_BITS_P-1:0]   result_s;

  assign x_ready   = x_ready_r;
  assign y_valid   = y_valid_r;
  assign y         = y_r;
  assign y_channel = y_ch_r;

  // Shared datapath: coefficient/operand select, single multiplier, stage result.
  always_comb begin
    accept_s    = (state_r == IDLE) && x_valid;
    ch_valid_s  = (32'(x_channel) < 32'(NR_OF_CHANNELS_P));
    clear_now_s = (state_r == IDLE) && (clear_state || clr_pend_r);
    s_next_s    = s_r + S_W'(1'b1);
    byp0_s      = cr_bypass[0] | ~ch_valid_s;
    byp_next_s  = cr_bypass[s_next_s] | ~ch_valid_r;
    ch_idx_s    = ch_valid_r ? ch_r : {CH_WIDTH_P{1'b0}};
    coef_idx_s  = COEF_ADDR_WIDTH_P'(s_r) * FIVE_C + COEF_ADDR_WIDTH_P'(k_r);
    coef_s      = active_r[coef_idx_s];
    case (k_r)
      3'd0:    op_s = stage_in_r;
      3'd1:    op_s = x1_r[ch_idx_s][s_r];
      3'd2:    op_s = x2_r[ch_idx_s][s_r];
      3'd3:    op_s = y1_r[ch_idx_s][s_r];
      3'd4:    op_s = y2_r[ch_idx_s][s_r];
      default: op_s = {N_BITS_P{1'b0}};
    endcase
    // Sign-extend both operands so the low 2N bits hold the signed product.
    prod_s     = {{N_BITS_P{coef_s[N_BITS_P-1]}}, coef_s} * {{N_BITS_P{op_s[N_BITS_P-1]}}, op_s};
    prod_ext_s = {{3{prod_s[PROD_W-1]}}, prod_s};
    shifted_s  = acc_r >>> Q_BITS_P;
    if (bypass_r) begin
      result_s = stage_in_r;
    end else begin
      result_s = reduce_f(shifted_s);
    end
  end

  // Sequencer: accept, per-stage MAC/STORE, output pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      s_r        <= {S_W{1'b0}};
      k_r        <= 3'd0;
      ch_r       <= {CH_WIDTH_P{1'b0}};
      ch_valid_r <= 1'b0;
      bypass_r   <= 1'b0;
      stage_in_r <= {N_BITS_P{1'b0}};
      acc_r      <= {ACC_W{1'b0}};
      x_ready_r  <= 1'b1;
      y_valid_r  <= 1'b0;
      y_r        <= {N_BITS_P{1'b0}};
      y_ch_r     <= {CH_WIDTH_P{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          y_valid_r <= 1'b0;
          if (accept_s) begin
            stage_in_r <= x;
            ch_r       <= x_channel;
            ch_valid_r <= ch_valid_s;
            s_r        <= {S_W{1'b0}};
            k_r        <= 3'd0;
            bypass_r   <= byp0_s;
            state_r    <= byp0_s ? STORE : MAC;
            x_ready_r  <= 1'b0;
          end else begin
            x_ready_r  <= 1'b1;
          end
        end
        MAC: begin
          if (k_r == 3'd0) begin
            acc_r <= prod_ext_s;
          end else if (k_r >= 3'd3) begin
            acc_r <= acc_r - prod_ext_s;
          end else begin
            acc_r <= acc_r + prod_ext_s;
          end
          if (k_r == 3'd4) begin
            k_r     <= 3'd0;
            state_r <= STORE;
          end else begin
            k_r     <= k_r + 3'd1;
          end
        end
        STORE: begin
          stage_in_r <= result_s;
          k_r        <= 3'd0;
          if (s_r == LAST_C) begin
            y_r       <= result_s;
            y_ch_r    <= ch_r;
            y_valid_r <= 1'b1;
            state_r   <= OUTPUT;
          end else begin
            s_r      <= s_next_s;
            bypass_r <= byp_next_s;
            state_r  <= byp_next_s ? STORE : MAC;
          end
        end
        OUTPUT: begin
          y_valid_r <= 1'b0;
          x_ready_r <= 1'b1;
          state_r   <= IDLE;
        end
        default: begin
          y_valid_r <= 1'b0;
          x_ready_r <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  // A clear seen while busy is held until the FSM is back in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_pend_r <= 1'b0;
    end else if (state_r == IDLE) begin
      clr_pend_r <= 1'b0;
    end else if (clear_state) begin
      clr_pend_r <= 1'b1;
    end else begin
      clr_pend_r <= clr_pend_r;
    end
  end

  // Coefficient shadow writes and shadow-to-active copy on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCOEF; i++) begin
        shadow_r[i] <= {N_BITS_P{1'b0}};
        active_r[i] <= {N_BITS_P{1'b0}};
      end
    end else begin
      if (cr_coef_wen && (cr_coef_addr < NCOEF_C)) begin
        shadow_r[cr_coef_addr] <= cr_coef_wdata;
      end
      if (accept_s) begin
        for (int i = 0; i < NCOEF; i++) begin
          if (cr_coef_wen && (cr_coef_addr == COEF_ADDR_WIDTH_P'(i))) begin
            active_r[i] <= cr_coef_wdata;
          end else begin
            active_r[i] <= shadow_r[i];
          end
        end
      end
    end
  end

  // Per-channel, per-stage filter history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NR_OF_CHANNELS_P; c++) begin
        for (int s = 0; s < NR_OF_STAGES_P; s++) begin
          x1_r[c][s] <= {N_BITS_P{1'b0}};
          x2_r[c][s] <= {N_BITS_P{1'b0}};
          y1_r[c][s] <= {N_BITS_P{1'b0}};
          y2_r[c][s] <= {N_BITS_P{1'b0}};
        end
      end
    end else if (clear_now_s) begin
      for (int c = 0; c < NR_OF_CHANNELS_P; c++) begin
        for (int s = 0; s < NR_OF_STAGES_P; s++) begin
          x1_r[c][s] <= {N_BITS_P{1'b0}};
          x2_r[c][s] <= {N_BITS_P{1'b0}};
          y1_r[c][s] <= {N_BITS_P{1'b0}};
          y2_r[c][s] <= {N_BITS_P{1'b0}};
        end
      end
    end else if ((state_r == STORE) && !bypass_r) begin
      x2_r[ch_idx_s][s_r] <= x1_r[ch_idx_s][s_r];
      x1_r[ch_idx_s][s_r] <= stage_in_r;
      y2_r[ch_idx_s][s_r] <= y1_r[ch_idx_s][s_r];
      y1_r[ch_idx_s][s_r] <= result_s;
    end
  end

endmodule
